// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the iterative 8x8 multiplier controller:
//   - controller state encoding (IDLE / MUL / DONE)
//   - operand, product and nibble widths, number of nibble steps
//   - step -> partial-product shift lookup
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int unsigned STEPS = 4;
    localparam int unsigned OPW   = 8;
    localparam int unsigned PW    = 16;
    localparam int unsigned NIBW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step order: lo*lo, hi*lo, lo*hi, hi*hi.
    function automatic logic [3:0] step_shift(input logic [1:0] step);
        logic [3:0] shift;
        case (step)
            2'd0:    shift = 4'd0;
            2'd1:    shift = 4'd4;
            2'd2:    shift = 4'd4;
            default: shift = 4'd8;
        endcase
        return shift;
    endfunction

endpackage

// File: rtl/array4.sv
// -----------------------------------------------------------------------------
// array4
// Combinational 4x4 unsigned array multiplier. Each multiplier bit gates a
// copy of the multiplicand; the gated rows are shifted and summed.
// Ports:
//   a  in  4  multiplicand
//   b  in  4  multiplier
//   p  out 8  product a*b
// -----------------------------------------------------------------------------
module array4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            p = p + ({4'b0000, (a & {4{b[i]}})} << i);
        end
    end

endmodule

// File: rtl/mul8_iter_ctrl.sv
// -----------------------------------------------------------------------------
// mul8_iter_ctrl
// Sequential 8x8 unsigned multiplier. One 4x4 array multiplier is reused over
// four nibble-product steps; shifted partial products are accumulated into a
// 16-bit result. Valid/ready handshakes on operand and result sides.
// Parameters:
//   ZERO_SKIP  when nonzero, a zero operand skips the nibble steps and the
//              result 0 is presented one cycle after accept
// Ports:
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous active-high reset
//   in_valid   in   1   operands a/b valid
//   in_ready   out  1   operands can be accepted (IDLE only)
//   a          in   8   multiplicand
//   b          in   8   multiplier
//   out_valid  out  1   result p valid (DONE)
//   out_ready  in   1   consumer accepts p
//   p          out  16  product a*b, held until the next result load
//   busy       out  1   high in MUL and DONE
// -----------------------------------------------------------------------------
module mul8_iter_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned ZERO_SKIP = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    a,
    input  logic [7:0]    b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   p,
    output logic          busy
);

    state_t           state;
    logic [1:0]       step;
    logic [OPW-1:0]   a_r;
    logic [OPW-1:0]   b_r;
    logic [PW-1:0]    acc;
    logic             skip_r;

    logic [NIBW-1:0]  nib_a;
    logic [NIBW-1:0]  nib_b;
    logic [2*NIBW-1:0] pp;
    logic [PW-1:0]    term;
    logic [PW-1:0]    acc_next;
    logic             take_skip;

    // step[0] picks the high nibble of a_r, step[1] the high nibble of b_r.
    always_comb begin
        nib_a = step[0] ? a_r[7:4] : a_r[3:0];
        nib_b = step[1] ? b_r[7:4] : b_r[3:0];
    end

    array4 u_array4 (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    always_comb begin
        term      = {{(PW-2*NIBW){1'b0}}, pp} << step_shift(step);
        acc_next  = acc + term;
        take_skip = (ZERO_SKIP != 0) && ((a == '0) || (b == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            step      <= '0;
            acc       <= '0;
            p         <= '0;
            a_r       <= '0;
            b_r       <= '0;
            skip_r    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        acc      <= '0;
                        step     <= '0;
                        skip_r   <= take_skip;
                        state    <= MUL;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MUL: begin
                    // A skipped operation spends exactly one cycle here so its
                    // zero result is presented one edge after accept.
                    if (skip_r) begin
                        p         <= '0;
                        acc       <= '0;
                        step      <= '0;
                        skip_r    <= 1'b0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        acc  <= acc_next;
                        step <= step + 2'd1;
                        if (step == 2'(STEPS - 1)) begin
                            p         <= acc_next;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    step      <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul8_iter_ctrl
// Bench for mul8_iter_ctrl: one instance without zero skip (scoreboarded),
// one with zero skip (directed latency/result checks).
// -----------------------------------------------------------------------------
module tb_mul8_iter_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] p;

    logic        z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_busy;
    logic [7:0]  z_a, z_b;
    logic [15:0] z_p;

    mul8_iter_ctrl #(.ZERO_SKIP(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    mul8_iter_ctrl #(.ZERO_SKIP(1)) dut_zs (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (z_in_valid),
        .in_ready  (z_in_ready),
        .a         (z_a),
        .b         (z_b),
        .out_valid (z_out_valid),
        .out_ready (z_out_ready),
        .p         (z_p),
        .busy      (z_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected products and accept-edge numbers are pushed when an
    // accept is about to happen and popped when the DUT presents results.
    logic [15:0] exp_q[$];
    int          acc_q[$];
    logic        hs_prev = 1'b0;
    logic        ov_prev = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
            hs_prev = 1'b0;
            ov_prev = 1'b0;
        end else begin
            if (hs_prev) begin
                check("in_ready_after_hs", in_ready, 1);
                check("out_valid_after_hs", out_valid, 0);
            end
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) check("spurious_out_valid", out_valid, 0);
                else check("latency", cyc - acc_q.pop_front(), 4);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_result", out_valid, 0);
                else check("p", p, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({8'h00, a} * {8'h00, b});
                acc_q.push_back(cyc + 1);
            end
            hs_prev = out_valid && out_ready;
            ov_prev = out_valid;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 30 && !in_ready; i++) tick();
        check("idle_wait", in_ready, 1);
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y);
        wait_idle();
        in_valid = 1'b1;
        a = x;
        b = y;
        tick();
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        wait_idle();
    endtask

    task automatic z_op(input logic [7:0] x, input logic [7:0] y,
                        input int exp_lat, input logic [15:0] exp_p);
        int n;
        for (int i = 0; i < 30 && !z_in_ready; i++) tick();
        z_in_valid = 1'b1;
        z_a = x;
        z_b = y;
        tick();
        z_in_valid = 1'b0;
        z_a = 8'($urandom);
        z_b = 8'($urandom);
        n = 0;
        while (!z_out_valid && n < 10) begin
            tick();
            n++;
        end
        check("zs_latency", n, exp_lat);
        check("zs_p", z_p, exp_p);
        check("zs_busy", z_busy, 1);
        tick();
        check("zs_in_ready_after_hs", z_in_ready, 1);
    endtask

    logic [7:0] bb_a [3] = '{8'h01, 8'h10, 8'hF0};
    logic [7:0] bb_b [3] = '{8'h01, 8'h10, 8'h0F};

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        z_in_valid = 1'b0; z_out_ready = 1'b1; z_a = '0; z_b = '0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_p", p, 0);
        check("rst_zs_in_ready", z_in_ready, 1);
        reset = 1'b0;

        run_op(8'h12, 8'h34);
        run_op(8'hFF, 8'hFF);
        run_op(8'hA5, 8'h00);

        // Backpressure: result held while out_ready is low.
        wait_idle();
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'h0F; b = 8'h10;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        check("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check("bp_p_held", p, 16'h00F0);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
            check("bp_out_valid_held", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_busy", busy, 0);

        // Reset sampled while step 2 is pending.
        wait_idle();
        in_valid = 1'b1; a = 8'h80; b = 8'h80;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_p", p, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_no_result", out_valid, 0);
        end
        run_op(8'h03, 8'h05);

        // Back-to-back with in_valid held high.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 30 && !in_ready; i++) tick();
            check("b2b_ready", in_ready, 1);
            a = bb_a[k];
            b = bb_b[k];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        wait_idle();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);

        // Zero-skip instance.
        z_op(8'h12, 8'h34, 4, 16'h03A8);
        z_op(8'hA5, 8'h00, 1, 16'h0000);
        z_op(8'h00, 8'h7B, 1, 16'h0000);
        z_op(8'hFF, 8'hFF, 4, 16'hFE01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

endmodule
